// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / stall controller.
//   fwd_sel_e   : operand source select driven onto fwda / fwdb
//   mdu_state_e : state of the multiply/divide unit tracker
//   REG_W/CNT_W : register-number and MDU counter widths
//   reg_hit()   : "this stage writes a real register that matches src"
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        FWD_RF       = 2'b00,  // register file value
        FWD_EX_ALU   = 2'b01,  // ALU result sitting in EX
        FWD_MEM_ALU  = 2'b10,  // ALU result sitting in MEM
        FWD_MEM_LOAD = 2'b11   // load data returned in MEM
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Register 0 is hard-wired to zero, so a write to it never produces a hazard.
    function automatic logic reg_hit(input logic             wen,
                                     input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
        return wen && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational operand forwarding select for one source operand.
// Ports:
//   src_i                    : ID-stage source register number
//   ewreg_i/em2reg_i/ern_i   : EX-stage write enable, load flag, destination
//   mwreg_i/mm2reg_i/mrn_i   : MEM-stage write enable, load flag, destination
//   fwd_o                    : selected source (pipe_ctrl_pkg::fwd_sel_e encoding)
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic             ewreg_i,
    input  logic             em2reg_i,
    input  logic [REG_W-1:0] ern_i,
    input  logic             mwreg_i,
    input  logic             mm2reg_i,
    input  logic [REG_W-1:0] mrn_i,
    output logic [1:0]       fwd_o
);

    fwd_sel_e sel;

    // The youngest producer (EX) wins. A load still in EX has no data yet, so it
    // cannot be forwarded; that case is covered by the load-use stall instead.
    always_comb begin
        sel = FWD_RF;
        if (reg_hit(ewreg_i, ern_i, src_i) && !em2reg_i) begin
            sel = FWD_EX_ALU;
        end else if (reg_hit(mwreg_i, mrn_i, src_i)) begin
            sel = mm2reg_i ? FWD_MEM_LOAD : FWD_MEM_ALU;
        end
    end

    assign fwd_o = sel;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall and
// multiply/divide unit (MDU) occupancy tracking.
// Ports:
//   clock, resetn            : rising-edge clock, asynchronous active-low reset
//   rs, rt, use_rs, use_rt   : ID source registers and whether they are read
//   ewreg, em2reg, ern       : EX-stage write enable, load flag, destination
//   mwreg, mm2reg, mrn       : MEM-stage write enable, load flag, destination
//   mdu_start, mdu_use       : ID instruction starts a mul/div / reads hi/lo
//   wpcir                    : PC and IF/ID write enable (0 = stall)
//   bubble                   : squash ID/EX control fields this cycle
//   fwda, fwdb               : forwarding selects for rs / rt
//   mdu_busy, mdu_done       : MDU occupied / single-cycle completion pulse
// MDU_LAT is the MDU latency in cycles, legal range 2..255.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [REG_W-1:0] ern,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [REG_W-1:0] mrn,
    input  logic             mdu_start,
    input  logic             mdu_use,
    output logic             wpcir,
    output logic             bubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mdu_busy,
    output logic             mdu_done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    logic load_use;
    logic mdu_stall;
    logic stall;
    logic accept;

    // ------------------------------------------------------------------
    // Forwarding: one identical unit per operand, independent of reset.
    // ------------------------------------------------------------------
    pipe_fwd_unit u_fwd_a (
        .src_i    (rs),
        .ewreg_i  (ewreg),
        .em2reg_i (em2reg),
        .ern_i    (ern),
        .mwreg_i  (mwreg),
        .mm2reg_i (mm2reg),
        .mrn_i    (mrn),
        .fwd_o    (fwda)
    );

    pipe_fwd_unit u_fwd_b (
        .src_i    (rt),
        .ewreg_i  (ewreg),
        .em2reg_i (em2reg),
        .ern_i    (ern),
        .mwreg_i  (mwreg),
        .mm2reg_i (mm2reg),
        .mrn_i    (mrn),
        .fwd_o    (fwdb)
    );

    // ------------------------------------------------------------------
    // Stall sources. Unlike forwarding, stalls honour use_rs / use_rt so an
    // instruction that does not read a register is never held for it.
    // ------------------------------------------------------------------
    assign load_use = ewreg && em2reg && (ern != '0) &&
                      ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));

    // Any MDU-dependent instruction waits while the unit is occupied,
    // including the final (done) cycle; it is accepted next cycle in IDLE.
    assign mdu_stall = (state_q == ST_BUSY) && (mdu_start || mdu_use);

    // Gating with resetn keeps the pipeline free-running while reset is held,
    // even if the load-use inputs happen to match.
    assign stall = resetn && (load_use || mdu_stall);

    // A start that coincides with a load-use stall is not taken; the held
    // IF/ID register re-presents it once the stall clears.
    assign accept = (state_q == ST_IDLE) && mdu_start && !load_use;

    assign wpcir    = !stall;
    assign bubble   = stall;
    assign mdu_busy = (state_q == ST_BUSY);
    assign mdu_done = (state_q == ST_BUSY) && (cnt_q == '0);

    // ------------------------------------------------------------------
    // MDU occupancy FSM: cnt counts down the remaining busy cycles.
    // ------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments and an async reset so every
    // flop samples the pre-edge value; reset mid-BUSY simply drops the op.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 32: multiply/divide unit (MDU) latency in cycles, legal range 2..255.
REQ-002 SHALL have port clock  in  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports rs, rt  in  5 each  ID-stage source register numbers.
REQ-005 SHALL have ports use_rs, use_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 SHALL have ports ewreg, em2reg  in  1 each, and ern  in  5  EX-stage write enable, load flag, destination register.
REQ-007 SHALL have ports mwreg, mm2reg  in  1 each, and mrn  in  5  MEM-stage equivalents.
REQ-008 SHALL have ports mdu_start, mdu_use  in  1 each  ID instruction issues a mul/div / reads hi/lo.
REQ-009 SHALL have port wpcir  out  1  write enable to the PC and IF/ID register (0 = stall).
REQ-010 SHALL have port bubble  out  1  zeroes the ID/EX control fields this cycle.
REQ-011 SHALL have ports fwda, fwdb  out  2 each  operand source select for rs / rt.
REQ-012 SHALL have ports mdu_busy  out  1, and mdu_done  out  1  single-cycle completion pulse.

Function
REQ-013 SHALL encode fwd selects as: 00 register file; 01 EX ALU result; 10 MEM ALU result; 11 MEM load data.
REQ-014 SHALL select fwda = 01 when ewreg, ern != 0, ern == rs and em2reg = 0.
REQ-015 SHALL otherwise select fwda = 10 or 11 (by mm2reg) when mwreg, mrn != 0 and mrn == rs; else 00.
REQ-016 SHALL give EX priority over MEM; the rule for fwdb is identical using rt.
REQ-017 SHALL never forward register 0; use_rs / use_rt do not gate fwd outputs, only stall detection.
REQ-018 SHALL detect load-use when ewreg & em2reg & ern != 0 & ((use_rs & ern == rs) | (use_rt & ern == rt)).
REQ-019 SHALL, on load-use, drive wpcir = 0 and bubble = 1 combinationally for exactly that cycle; the next cycle resolves via fwd = 11 without further stall.
REQ-020 SHALL implement FSM states IDLE and BUSY with an 8-bit down-counter cnt.
REQ-021 SHALL accept mdu_start only in IDLE with no stall that cycle; on acceptance: BUSY, cnt = MDU_LAT-1.
REQ-022 SHALL, in BUSY, decrement cnt each cycle; when cnt == 0 go to IDLE and assert mdu_done for that cycle.
REQ-023 SHALL drive mdu_busy = 1 exactly while in BUSY.
REQ-024 SHALL, in BUSY, stall any ID instruction with mdu_start or mdu_use: wpcir = 0, bubble = 1; independent instructions proceed.
REQ-025 SHALL still stall mdu_start/mdu_use in the cnt == 0 cycle; acceptance occurs the following cycle in IDLE.
REQ-026 SHALL not accept mdu_start coincident with a load-use stall; it is re-presented by the held IF/ID and accepted when the stall clears.
REQ-027 SHALL have stall = load-use OR MDU stall; wpcir = ~stall, bubble = stall, with no other sources.

Reset
REQ-028 SHALL, while resetn = 0, force state IDLE, cnt = 0, mdu_busy = 0, mdu_done = 0, wpcir = 1, bubble = 0.
REQ-029 SHALL allow reset mid-BUSY, which abandons the operation with no mdu_done pulse.
REQ-030 SHALL keep fwd outputs purely combinational from inputs, unaffected by reset.

Structure
REQ-031 SHALL place fwd select constants and the FSM state type in shared package pipe_ctrl_pkg.
REQ-032 SHALL implement forwarding as sub-module pipe_fwd_unit (combinational), instantiated once per operand.
REQ-033 SHALL keep only state and cnt as sequential elements; no other registers.

Verification
REQ-034 SHALL check: EX ALU ern = 5, ewreg = 1, rs = 5, use_rs = 1 -> fwda = 01, wpcir = 1, bubble = 0.
REQ-035 SHALL check: EX load ern = 7, rt = 7, use_rt = 1 -> one cycle wpcir = 0, bubble = 1; next cycle (load in MEM) fwdb = 11, wpcir = 1.
REQ-036 SHALL check: ern = mrn = 3, both write, rs = 3 -> fwda = 01; with ern = 0, rs = 0 -> fwda = 00.
REQ-037 SHALL check: MDU_LAT = 4, mdu_start accepted at cycle 0 -> mdu_busy cycles 1-4, mdu_done at cycle 4, mdu_use at cycle 2 stalled through cycle 4, accepted cycle 5.
REQ-038 SHALL check: mdu_start with simultaneous load-use -> not accepted (mdu_busy stays 0), accepted the next cycle.
REQ-039 SHALL check: resetn low at BUSY cnt = 2 -> immediately mdu_busy = 0, wpcir = 1, no mdu_done after release.
